// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl encodings (also used by the ALU decoder),
// execute-unit FSM states and a small op-class helper.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_SRA    = 4'b0110;
  localparam logic [3:0] ALU_OR     = 4'b0111;
  localparam logic [3:0] ALU_AND    = 4'b1000;
  localparam logic [3:0] ALU_PASS_B = 4'b1001;
  localparam logic [3:0] ALU_SUB    = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between the issue stage and the execute ALU.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  // A transfer happens on a rising edge where valid and ready are both high;
  // the sender holds its payload stable while valid is high and ready is low.
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_comb_ops.sv
// Single-cycle ALU operations; shift codes and undefined codes yield 0 here.
module alu_comb_ops
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] comb_result
);

  logic lt_signed;
  logic lt_unsigned;

  assign lt_signed   = $signed(src_a) < $signed(src_b);
  assign lt_unsigned = src_a < src_b;

  always_comb begin
    comb_result = '0;
    case (alu_control)
      ALU_ADD:    comb_result = src_a + src_b;
      ALU_SUB:    comb_result = src_a - src_b;
      ALU_SLT:    comb_result = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU:   comb_result = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_XOR:    comb_result = src_a ^ src_b;
      ALU_OR:     comb_result = src_a | src_b;
      ALU_AND:    comb_result = src_a & src_b;
      ALU_PASS_B: comb_result = src_b;
      default:    comb_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops via alu_comb_ops, shifts one bit per
// cycle in the result register, valid/ready on both sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_exec_unit_if.slave       bus,
  output alu_state_e           dbg_state
);

  alu_state_e      state;
  logic [XLEN-1:0] result_q;
  logic            out_valid_q;
  logic [SHW-1:0]  shift_cnt;
  logic [3:0]      shift_kind;

  logic [XLEN-1:0] comb_result;
  logic [XLEN-1:0] shift_next;
  logic [SHW-1:0]  shamt;
  logic            accept;
  logic            in_ready;

  alu_comb_ops #(.XLEN(XLEN)) u_comb_ops (
    .alu_control (bus.alu_control),
    .src_a       (bus.src_a),
    .src_b       (bus.src_b),
    .comb_result (comb_result)
  );

  // DONE can hand off to a new op in the same edge the result is consumed.
  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign shamt    = bus.src_b[SHW-1:0];

  always_comb begin
    shift_next = result_q;
    case (shift_kind)
      ALU_SLL: shift_next = {result_q[XLEN-2:0], 1'b0};
      ALU_SRL: shift_next = {1'b0, result_q[XLEN-1:1]};
      ALU_SRA: shift_next = {result_q[XLEN-1], result_q[XLEN-1:1]};
      default: shift_next = result_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      shift_cnt   <= '0;
      shift_kind  <= ALU_SLL;
    end else if (accept) begin
      if (is_shift_op(bus.alu_control) && (shamt != '0)) begin
        state       <= ST_SHIFT;
        result_q    <= bus.src_a;
        shift_kind  <= bus.alu_control;
        shift_cnt   <= shamt;
        out_valid_q <= 1'b0;
      end else begin
        // A zero-distance shift is just src_a, so it completes like any single-cycle op.
        state       <= ST_DONE;
        result_q    <= is_shift_op(bus.alu_control) ? bus.src_a : comb_result;
        out_valid_q <= 1'b1;
      end
    end else begin
      case (state)
        ST_SHIFT: begin
          result_q  <= shift_next;
          shift_cnt <= shift_cnt - 1'b1;
          if (shift_cnt == SHW'(1)) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
  assign dbg_state     = state;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, randomized ops against a
// plain-arithmetic reference, backpressure handoff and reset mid-shift.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic       clk;
  logic       rst_n;
  alu_state_e dbg_state;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] code, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    int unsigned n;
    n = b % XLEN;
    case (code)
      4'd0:    return a + b;
      4'd11:   return a - b;
      4'd1:    return a << n;
      4'd5:    return a >> n;
      4'd6:    return $unsigned($signed(a) >>> n);
      4'd2:    return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd3:    return (a < b) ? 1 : 0;
      4'd4:    return a ^ b;
      4'd7:    return a | b;
      4'd8:    return a & b;
      4'd9:    return b;
      default: return '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] code, input logic [XLEN-1:0] b);
    if (code == 4'd1 || code == 4'd5 || code == 4'd6) return 1 + int'(b % XLEN);
    return 1;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the result was consumed.
  task automatic run_op(input logic [3:0] code, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output logic [XLEN-1:0] res, output logic z, output int lat);
    int guard;
    bus.alu_control = code;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.in_valid    = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_wait", XLEN'(guard < 100), 1);
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'($urandom_range(0, 15));
    bus.src_a       = $urandom;
    bus.src_b       = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    z   = bus.zero;
    @(posedge clk); #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string           name;
    logic [3:0]      code;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp_res;
    logic            exp_zero;
    int              exp_lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [XLEN-1:0] res;
    logic            z;
    int              lat;
    int              rises;

    vecs[0]  = '{"add_wrap",  ALU_ADD,    32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1};
    vecs[1]  = '{"sub",       ALU_SUB,    32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1};
    vecs[2]  = '{"slt",       ALU_SLT,    32'h8000_0000, 32'h1,         32'h1,         1'b0, 1};
    vecs[3]  = '{"sltu",      ALU_SLTU,   32'h8000_0000, 32'h1,         32'h0,         1'b1, 1};
    vecs[4]  = '{"sra31",     ALU_SRA,    32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 32};
    vecs[5]  = '{"srl31",     ALU_SRL,    32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 32};
    vecs[6]  = '{"sll0",      ALU_SLL,    32'h1,         32'h0,         32'h1,         1'b0, 1};
    vecs[7]  = '{"undef",     4'b1111,    32'hDEAD_BEEF, 32'h1234_5678, 32'h0,         1'b1, 1};
    vecs[8]  = '{"pass_b",    ALU_PASS_B, 32'h0,         32'h1234_5000, 32'h1234_5000, 1'b0, 1};
    vecs[9]  = '{"and",       ALU_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1};
    vecs[10] = '{"or",        ALU_OR,     32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1};
    vecs[11] = '{"sll_mask",  ALU_SLL,    32'h3,         32'h0000_0024, 32'h0000_0030, 1'b0, 5};

    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.alu_control = 4'h0;
    bus.src_a       = '0;
    bus.src_b       = '0;
    rst_n           = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", XLEN'(bus.out_valid), 0);
    check("rst_result",    bus.result,           0);
    check("rst_zero",      XLEN'(bus.zero),      1);
    check("rst_in_ready",  XLEN'(bus.in_ready),  1);
    check("rst_state",     XLEN'(dbg_state),     XLEN'(ST_IDLE));

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].code, vecs[i].a, vecs[i].b, res, z, lat);
      check({vecs[i].name, "_result"},  res,        vecs[i].exp_res);
      check({vecs[i].name, "_zero"},    XLEN'(z),   XLEN'(vecs[i].exp_zero));
      check({vecs[i].name, "_latency"}, XLEN'(lat), XLEN'(vecs[i].exp_lat));
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [3:0]      code;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] exp;
      code = 4'($urandom_range(0, 15));
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 40)) : $urandom;
      exp_q.push_back(ref_alu(code, a, b));
      run_op(code, a, b, res, z, lat);
      exp = exp_q.pop_front();
      check("rand_result",  res,        exp);
      check("rand_zero",    XLEN'(z),   XLEN'(exp == '0));
      check("rand_latency", XLEN'(lat), XLEN'(ref_lat(code, b)));
    end

    // Backpressure: result held while out_ready is low, then same-edge handoff
    bus.out_ready   = 1'b0;
    bus.alu_control = ALU_ADD;
    bus.src_a       = 32'd2;
    bus.src_b       = 32'd3;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", XLEN'(bus.out_valid), 1);
      check("bp_result",    bus.result,           32'd5);
      check("bp_in_ready",  XLEN'(bus.in_ready),  0);
      @(posedge clk); #1;
    end
    bus.alu_control = ALU_XOR;
    bus.src_a       = 32'hF0;
    bus.src_b       = 32'hFF;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    #1;
    check("handoff_in_ready", XLEN'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("handoff_out_valid", XLEN'(bus.out_valid), 1);
    check("handoff_result",    bus.result,           32'h0F);
    check("handoff_zero",      XLEN'(bus.zero),      0);
    @(posedge clk); #1;
    check("handoff_idle", XLEN'(bus.out_valid), 0);

    // Reset in the middle of a shift
    bus.alu_control = ALU_SLL;
    bus.src_a       = 32'h1;
    bus.src_b       = 32'd20;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midshift_state", XLEN'(dbg_state), XLEN'(ST_SHIFT));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_state",     XLEN'(dbg_state),     XLEN'(ST_IDLE));
    check("midrst_out_valid", XLEN'(bus.out_valid), 0);
    check("midrst_result",    bus.result,           0);
    check("midrst_zero",      XLEN'(bus.zero),      1);
    rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) rises++;
      @(posedge clk); #1;
    end
    check("midrst_no_valid", XLEN'(rises), 0);
    check("midrst_in_ready", XLEN'(bus.in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit ALUControl code from the ALU decoder, plus two XLEN-bit operands.
- Produces a registered result and a zero flag for branch resolution.
- ADD/SUB/logic/compare/pass-B complete in one cycle. Shifts run iteratively, one bit position per cycle, to save area.
- Valid/ready handshakes on both sides let the pipeline stall during multi-cycle shifts.

Parameters:
- XLEN, 32, operand/result width.
- SHW, $clog2(XLEN), shift-amount width (5 for XLEN=32).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands and control code are valid.
- in_ready  out  1  unit can accept a new operation this cycle.
- alu_control  in  4  operation code from the ALU decoder.
- src_a  in  XLEN  operand A.
- src_b  in  XLEN  operand B; shift amount is src_b[SHW-1:0].
- out_valid  out  1  result and zero are valid.
- out_ready  in  1  downstream accepts the result.
- result  out  XLEN  registered result.
- zero  out  1  high when result == 0.

Behaviour:
- Codes:
  - 0000 ADD, 1011 SUB (A-B).
  - 0001 SLL, 0101 SRL, 0110 SRA.
  - 0010 SLT (signed; result 1/0), 0011 SLTU (unsigned).
  - 0100 XOR, 0111 OR, 1000 AND.
  - 1001 PASS_B (result = src_b).
  - Any other code: result 0, single-cycle, no error flag.
- Arithmetic wraps modulo 2^XLEN. No overflow or carry output.
- States: IDLE, SHIFT, DONE.
- Reset (rst_n low at a clock edge):
  - State -> IDLE; result=0, out_valid=0, shift counter=0.
  - Applies regardless of current state; an in-flight shift is discarded.
  - in_ready is 1 in the first cycle after reset.
- Acceptance: an operation is accepted when in_valid & in_ready are high at the clock edge.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational and allows back-to-back issue.
- IDLE + accept:
  - Non-shift op, or shift with amount 0: result computed and registered; go to DONE. Latency 1 (accept at T -> out_valid at T+1).
  - Shift with amount n>0: latch src_a into result register, latch kind and count n; go to SHIFT.
- SHIFT, each cycle:
  - Shift result by one position (SLL: fill 0 at LSB; SRL: fill 0 at MSB; SRA: replicate MSB); decrement count.
  - When count==1 at the edge, go to DONE.
  - Shift by n: out_valid at T+1+n. Maximum XLEN-1 = 31 shift cycles.
- SHIFT ignores in_valid (in_ready=0) and out_ready.
- DONE:
  - out_valid=1; result and zero held stable until out_ready=1.
  - If out_ready & in_valid: accept the new op in the same edge (as from IDLE).
  - If out_ready & !in_valid: go to IDLE, out_valid->0.
- In IDLE and SHIFT, out_valid=0. result may change but is don't-care when out_valid=0.
- zero is derived from the registered result (combinational compare). Its reset value is 1, since result=0.
- Operand or code changes while not accepted have no effect.

Decomposition:
- Shared package alu_pkg:
  - 4-bit localparams for every ALUControl code, shared with the ALU decoder so encodings stay in one place.
  - State encoding enum for IDLE/SHIFT/DONE.
- One sub-module, alu_comb_ops: purely combinational single-cycle ops (ADD/SUB/SLT/SLTU/XOR/OR/AND/PASS_B, plus the default 0).
- The top level holds the FSM, shift counter, and result register.

Test Plan:
- Reset behaviour: hold rst_n=0 for 2 cycles, release -> out_valid=0, result=0, zero=1, in_ready=1.
- Single-cycle ops:
  - ADD A=0xFFFFFFFF, B=1 -> next cycle out_valid=1, result=0, zero=1.
  - SUB A=5, B=7 -> 0xFFFFFFFE.
  - SLT A=0x80000000, B=1 -> 1; SLTU with the same operands -> 0.
- Shifts:
  - SRA A=0x80000000, B=31 -> out_valid exactly 32 cycles after accept, result=0xFFFFFFFF.
  - SRL with the same operands -> 0x00000001.
  - SLL A=1, B=0 -> 1-cycle latency, result=1.
- Backpressure:
  - ADD 2+3 with out_ready=0 for 5 cycles -> result=5 held, in_ready=0.
  - Raise out_ready with in_valid carrying XOR 0xF0^0xFF -> same-edge handoff; next cycle result=0x0F.
- Reset mid-shift: SLL A=1, B=20; assert rst_n=0 after 5 shift cycles -> IDLE next edge, out_valid never rises, result=0.
- Undefined and pass-B codes: code 1111 with any operands -> result=0, zero=1; 1001 with B=0x12345000 -> result=0x12345000.
